// File: rtl/arb_priority_aging.sv
// Lock-and-hold fixed-priority arbiter with anti-starvation aging.
// Owner keeps the bus until it drops req or hits MAX_HOLD; aged requesters win first.
module arb_priority_aging #(
  parameter int REQ_NUM   = 4,
  parameter int MAX_HOLD  = 8,
  parameter int AGE_LIMIT = 3,
  localparam int ID_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int AGE_W    = $clog2(AGE_LIMIT + 1),
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req,
  output logic [REQ_NUM-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [AGE_W-1:0]    age [REQ_NUM];

  logic [REQ_NUM-1:0]  urgent;
  logic [REQ_NUM-1:0]  cand;
  logic [REQ_NUM-1:0]  win_oh;
  logic [ID_W-1:0]     win_id;
  logic                own_req;
  logic                at_limit;
  logic                forced;

  function automatic logic [ID_W-1:0] lowest(input logic [REQ_NUM-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--)
      if (v[i]) idx = ID_W'(i);
    return idx;
  endfunction

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_W'(AGE_LIMIT)) ? a : a + AGE_W'(1);
  endfunction

  always_comb begin
    urgent = '0;
    for (int i = 0; i < REQ_NUM; i++)
      urgent[i] = (age[i] == AGE_W'(AGE_LIMIT));
    own_req  = |(req & grant);
    at_limit = (hold_cnt == HOLD_W'(MAX_HOLD));
    forced   = (state == BUSY) && own_req && at_limit;
    // On a forced release the current owner steps aside if anyone else is waiting.
    cand     = forced ? (req & ~grant) : req;
    win_id   = (|(cand & urgent)) ? lowest(cand & urgent) : lowest(cand);
    win_oh   = REQ_NUM'(1) << win_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      for (int i = 0; i < REQ_NUM; i++) age[i] <= '0;
    end else begin
      // Aging looks at the grant currently on the outputs, so a new owner clears next cycle.
      for (int i = 0; i < REQ_NUM; i++)
        age[i] <= (req[i] && !grant[i]) ? sat_inc(age[i]) : '0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= BUSY;
            grant       <= win_oh;
            grant_valid <= 1'b1;
            grant_id    <= win_id;
            hold_cnt    <= HOLD_W'(1);
          end
        end
        BUSY: begin
          if (own_req && !at_limit) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else if (|cand) begin
            grant       <= win_oh;
            grant_valid <= 1'b1;
            grant_id    <= win_id;
            hold_cnt    <= HOLD_W'(1);
            timeout     <= forced;
          end else if (forced) begin
            // Nobody else wants the bus: re-grant the same owner with a fresh window.
            hold_cnt <= HOLD_W'(1);
            timeout  <= 1'b1;
          end else begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            hold_cnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_priority_aging.sv
// Directed bench for arb_priority_aging with default parameters (4 req, hold 8, age 3).
module tb_arb_priority_aging;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  arb_priority_aging #(.REQ_NUM(4), .MAX_HOLD(8), .AGE_LIMIT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic to);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|g));
    chk({tag, ".id"}, 32'(grant_id), 32'(id));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) step();
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("idle", 4'b0000, 2'd0, 1'b0);
    req = 4'b0001;
    step();
    chk_out("first_grant", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_out("vol_idle", 4'b0000, 2'd0, 1'b0);

    // Lock: owner 1 keeps grant despite higher-priority req0.
    req = 4'b0010;
    step();
    chk_out("lock_g1", 4'b0010, 2'd1, 1'b0);
    req = 4'b0011;
    step();
    chk_out("lock_hold_a", 4'b0010, 2'd1, 1'b0);
    step();
    chk_out("lock_hold_b", 4'b0010, 2'd1, 1'b0);
    req = 4'b0001;
    step();
    chk_out("lock_switch", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_out("lock_idle", 4'b0000, 2'd0, 1'b0);

    // Single requester: re-granted with a timeout pulse every 8 cycles.
    req = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk_out($sformatf("solo_k%0d", k), 4'b0001, 2'd0, (k > 1) && ((k - 1) % 8 == 0));
    end
    req = 4'b0000;
    step();
    chk_out("solo_idle", 4'b0000, 2'd0, 1'b0);

    // Two requesters alternate every 8 cycles.
    req = 4'b0011;
    for (int k = 1; k <= 25; k++) begin
      logic odd;
      odd = (((k - 1) / 8) % 2) == 1;
      step();
      chk_out($sformatf("alt_k%0d", k), odd ? 4'b0010 : 4'b0001, odd ? 2'd1 : 2'd0,
              (k > 1) && ((k - 1) % 8 == 0));
    end
    req = 4'b0000;
    step();
    chk_out("alt_idle", 4'b0000, 2'd0, 1'b0);

    // Aging: req3 reaches urgency before req0, so it wins when owner 2 leaves.
    req = 4'b0100;
    step();
    chk_out("age_g2", 4'b0100, 2'd2, 1'b0);
    req = 4'b1100;
    step();
    step();
    chk_out("age_hold_a", 4'b0100, 2'd2, 1'b0);
    req = 4'b1101;
    step();
    step();
    chk_out("age_hold_b", 4'b0100, 2'd2, 1'b0);
    req = 4'b1001;
    step();
    chk_out("age_win3", 4'b1000, 2'd3, 1'b0);
    req = 4'b0001;
    step();
    chk_out("age_then0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_out("age_idle", 4'b0000, 2'd0, 1'b0);

    // Tie with both urgent: lowest index wins.
    req = 4'b0010;
    step();
    chk_out("tie_g1", 4'b0010, 2'd1, 1'b0);
    req = 4'b0111;
    repeat (3) step();
    req = 4'b0101;
    step();
    chk_out("tie_both", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_out("tie_idle", 4'b0000, 2'd0, 1'b0);

    // Only req2 urgent: it beats the non-urgent req0.
    req = 4'b0010;
    step();
    chk_out("tie2_g1", 4'b0010, 2'd1, 1'b0);
    req = 4'b0110;
    repeat (2) step();
    req = 4'b0111;
    step();
    req = 4'b0101;
    step();
    chk_out("tie_only2", 4'b0100, 2'd2, 1'b0);

    // Async reset mid-grant clears outputs without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_clr", 4'b0000, 2'd0, 1'b0);
    step();
    chk_out("async_hold", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("post_reset", 4'b0001, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_priority_aging.md
Name: arb_priority_aging

Overview:
- Lock-and-hold fixed-priority arbiter with anti-starvation aging. It shares one downstream resource among REQ_NUM requesters.
- The owner keeps the grant while its request stays high, up to a bounded hold time.
- Waiting requesters accumulate age. Aged ("urgent") requesters beat non-urgent ones, so low-index dominance cannot starve high-index requesters.
- Sits between requester ports and a shared bus/memory port, next to the absolute fixed-priority arbiters.

Parameters:
- REQ_NUM, 4, number of requesters (>=2); index 0 has highest base priority.
- MAX_HOLD, 8, max consecutive cycles one owner may hold the grant (>=1).
- AGE_LIMIT, 3, waiting cycles after which a requester becomes urgent (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  REQ_NUM  per-requester request level; held high for as long as access is wanted.
- grant  output  REQ_NUM  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  registered; equals |grant.
- grant_id  output  max(1,$clog2(REQ_NUM))  registered binary index of owner; 0 when idle.
- timeout  output  1  registered one-cycle pulse, coincident with the first grant cycle after a forced (MAX_HOLD) release.

Behaviour:
- Reset (async, any time incl. mid-grant): grant=0, grant_valid=0, grant_id=0, timeout=0, state=IDLE, hold_cnt=0, all age=0. No output glitch other than the async clear.
- State IDLE: at each edge, if req!=0, pick winner W from candidate set C=req. Next cycle: grant=onehot(W), grant_id=W, hold_cnt=1, state=BUSY. Latency = 1 clock from req sampled to grant.
- State BUSY, owner O, evaluated each edge:
  - Continue: req[O]=1 and hold_cnt<MAX_HOLD -> keep grant, hold_cnt+1.
  - Voluntary release: req[O]=0 -> C=req (req[O] already 0).
  - Forced release: req[O]=1 and hold_cnt==MAX_HOLD -> C=req & ~onehot(O).
  - On either release, if C!=0: switch directly to winner of C in the same edge, no idle bubble; hold_cnt=1.
  - Forced release with C==0: re-grant O, hold_cnt=1.
  - Voluntary release with C==0: grant=0, IDLE.
  - timeout=1 for exactly the cycle following any forced release, whether switched or re-granted; otherwise 0.
- Winner selection: urgent[i]=(age[i]==AGE_LIMIT). If C & urgent != 0, W = lowest index in C&urgent. Otherwise W = lowest index in C.
- Aging, per requester i, each edge, using the current registered grant:
  - req[i]=1 and grant[i]=0: age[i] increments, saturating at AGE_LIMIT.
  - Otherwise: age[i]=0.
  - Age is cleared the cycle after grant is received. Dropping req clears age.
- Widths: age $clog2(AGE_LIMIT+1) bits; hold_cnt $clog2(MAX_HOLD+1) bits; no wrap is possible.
- grant is always one-hot or zero. Ownership never changes while req[O]=1 and hold_cnt<MAX_HOLD, even if a higher/urgent request arrives. Preemption occurs only through MAX_HOLD.
- Requests dropping while not granted simply clear their age; no pending memory is kept.

Test Plan:
- Reset/idle: rst_n low then high, req=0000 -> grant=0000, grant_valid=0, grant_id=0, timeout=0. Set req=0001 -> grant=0001, grant_id=0 one edge later.
- Lock: req=0010 granted, then raise req0 (req=0011) -> grant stays 0010. Drop req1 at edge T -> grant=0001 right after T, no zero cycle.
- Timeout (MAX_HOLD=8):
  - req=0001 constant -> grant=0001 continuously; timeout pulses once every 8 cycles.
  - req=0011 constant -> grant alternates 0001/0010, 8 cycles each, timeout pulse at each switch.
- Aging (AGE_LIMIT=3): req=0100 granted; req3 up at edge t0; req0 up at t2; drop req2 at t5 -> age3=3 (urgent), age0<3 -> grant=1000, grant_id=3.
- Simultaneous tie: req=0001 and req=0100 both urgent at release -> grant=0001. Same with only req2 urgent -> grant=0100.
- Async reset mid-grant: assert rst_n low while grant=0100 between edges -> outputs clear immediately. After release with req held, re-grant follows the idle rules with ages starting at 0.
